cu_bus_xfer: RTL and testbench
==============================

CU_BUS_XFER -- requirements
Module: cu_bus_xfer

Interface
REQ-001 NUM_REGS, 8, number of 16-bit core registers served (2..16).
REQ-002 DATA_W, 16, register/bus data width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  transfer command present.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_op  in  2  00 MOVE, 01 CLEAR, 10 INC (only with macro), 11 reserved.
REQ-008 cmd_src  in  4  source register index.
REQ-009 cmd_dst  in  4  destination register index.
REQ-010 reg_data  in  NUM_REGS*DATA_W  flattened data_out of all registers, reg i at bits [i*DATA_W +: DATA_W].
REQ-011 bus_data  out  DATA_W  registered bus value driven to every register data_in.
REQ-012 load_en  out  NUM_REGS  one-hot load_enable per register.
REQ-013 reg_clr  out  NUM_REGS  one-hot synchronous clear per register.
REQ-014 done  out  1  one-cycle pulse at transfer completion.
REQ-015 err  out  1  one-cycle pulse on rejected command.

Function
REQ-016 The FSM SHALL have states IDLE, SELECT, LOAD, DONE.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid && cmd_ready; other commands are ignored.
REQ-018 On acceptance, src/dst/op SHALL be latched and IDLE->SELECT; all later stages use latched values only.
REQ-019 In SELECT, bus_data SHALL be loaded with reg_data[src] (MOVE), 0 (CLEAR), or reg_data[src]+1 modulo 2^DATA_W (INC; 0xFFFF -> 0x0000); then SELECT->LOAD.
REQ-020 In LOAD, exactly one bit load_en[dst] (MOVE/INC) or reg_clr[dst] (CLEAR) SHALL be 1 for one cycle while bus_data is held stable, giving the negedge-capturing register a mid-cycle sample; then LOAD->DONE.
REQ-021 In DONE, done SHALL be 1 for one cycle; then DONE->IDLE; latency acceptance-to-done = 3 cycles; command period = 4 cycles.
REQ-022 src == dst SHALL be legal; the register receives its own prior value (MOVE) or prior+1 (INC).
REQ-023 cmd_src or cmd_dst >= NUM_REGS, op 11, or op 10 without the macro SHALL be rejected at acceptance: err=1 next cycle, FSM stays IDLE, no load_en/reg_clr asserted.
REQ-024 bus_data SHALL hold its last value outside SELECT; load_en and reg_clr SHALL be all-zero outside LOAD.

Reset
REQ-025 reset low SHALL immediately force state IDLE, bus_data 0, load_en 0, reg_clr 0, done 0, err 0; cmd_ready is 1 after release.
REQ-026 reset asserted mid-transfer SHALL abort it with no load/clear pulse and no done.

Configuration
REQ-027 With CU_XFER_INC_EN defined, op 10 (INC) SHALL be supported per REQ-019; without it the incrementer SHALL be absent and op 10 rejected per REQ-023.

Structure
REQ-028 Package cu_pkg SHALL hold the FSM state enum, cmd_op encodings, and the DATA_W constant.
REQ-029 Source selection SHALL be a sub-module cu_bus_mux (combinational NUM_REGS:1 selector of reg_data by index).

Verification
REQ-030 reg3=0x1234, MOVE src3 dst5 -> bus_data=0x1234 in LOAD, load_en=0x20 for one cycle, done 3 cycles after acceptance.
REQ-031 CLEAR dst7 -> reg_clr=0x80 for one cycle, load_en=0 throughout, done pulses.
REQ-032 With CU_XFER_INC_EN: reg2=0xFFFF, INC src2 dst2 -> bus_data=0x0000, load_en=0x04; without the macro same command -> err=1, no load.
REQ-033 MOVE src9 dst1 (NUM_REGS=8) -> err pulse, cmd_ready stays 1, no strobes.
REQ-034 cmd_valid held high with two commands -> second accepted only 4 cycles after first; reset driven low in LOAD -> load_en drops at once, no done.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared FSM states, command op encodings and data width for the bus transfer unit
package cu_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_LOAD, ST_DONE} cu_state_e;
  typedef enum logic [1:0] {OP_MOVE = 2'b00, OP_CLEAR = 2'b01, OP_INC = 2'b10, OP_RSVD = 2'b11} cu_op_e;
endpackage

// File: rtl/cu_bus_mux.sv
// cu_bus_mux: combinational NUM_REGS:1 selector of flattened register data by index
module cu_bus_mux
  import cu_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic [NUM_REGS*DATA_W-1:0] reg_data_i,
  input  logic [3:0]                 sel_i,
  output logic [DATA_W-1:0]          data_o
);
  // out-of-range indices read as zero; the sequencer never selects them
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sel_i == 4'(i)) data_o = reg_data_i[i*DATA_W +: DATA_W];
  end
endmodule

// File: rtl/cu_bus_xfer.sv
// cu_bus_xfer: register-to-register bus transfer sequencer (IDLE -> SELECT -> LOAD -> DONE)
// Define CU_XFER_INC_EN to add the INC op (source + 1); without it INC is rejected.
module cu_bus_xfer
  import cu_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [3:0]                 cmd_src_i,
  input  logic [3:0]                 cmd_dst_i,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0]          bus_data_o,
  output logic [NUM_REGS-1:0]        load_en_o,
  output logic [NUM_REGS-1:0]        reg_clr_o,
  output logic                       done_o,
  output logic                       err_o
);
  cu_state_e         state_q, state_d;
  cu_op_e            op_q, op_d;
  logic [3:0]        src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0] bus_q, bus_d, src_data, sel_val;
  logic [NUM_REGS-1:0] dst_oh;
  logic              err_q, err_d, op_ok, idx_ok;

  cu_bus_mux #(.NUM_REGS(NUM_REGS)) u_mux (
    .reg_data_i(reg_data_i),
    .sel_i     (src_q),
    .data_o    (src_data)
  );

  assign idx_ok = 32'(cmd_src_i) < NUM_REGS && 32'(cmd_dst_i) < NUM_REGS;
`ifdef CU_XFER_INC_EN
  assign op_ok   = cmd_op_i != OP_RSVD;
  assign sel_val = op_q == OP_CLEAR ? '0 : op_q == OP_INC ? src_data + DATA_W'(1) : src_data;
`else
  assign op_ok   = cmd_op_i == OP_MOVE || cmd_op_i == OP_CLEAR;
  assign sel_val = op_q == OP_CLEAR ? '0 : src_data;
`endif

  assign dst_oh      = NUM_REGS'(1) << dst_q;
  assign cmd_ready_o = state_q == ST_IDLE;
  assign load_en_o   = (state_q == ST_LOAD && op_q != OP_CLEAR) ? dst_oh : '0;
  assign reg_clr_o   = (state_q == ST_LOAD && op_q == OP_CLEAR) ? dst_oh : '0;
  assign done_o      = state_q == ST_DONE;
  assign bus_data_o  = bus_q;
  assign err_o       = err_q;

  // next state: latch command on acceptance, drive the bus in SELECT, flag rejects
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    bus_d   = bus_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid_i) begin
        if (op_ok && idx_ok) begin
          state_d = ST_SELECT;
          op_d    = cu_op_e'(cmd_op_i);
          src_d   = cmd_src_i;
          dst_d   = cmd_dst_i;
        end else err_d = 1'b1;
      end
      ST_SELECT: begin
        bus_d   = sel_val;
        state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MOVE;
      src_q   <= '0;
      dst_q   <= '0;
      bus_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      bus_q   <= bus_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_cu_bus_xfer.sv
// tb_cu_bus_xfer: directed self-checking bench for cu_bus_xfer
module tb_cu_bus_xfer;
  import cu_pkg::*;
  localparam int N = 8;
  logic           clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, cmd_ready, done, err;
  logic [1:0]     cmd_op = '0;
  logic [3:0]     cmd_src = '0, cmd_dst = '0;
  logic [N*16-1:0] reg_data = '0;
  logic [15:0]    bus_data;
  logic [N-1:0]   load_en, reg_clr;
  int             n_run = 0, n_fail = 0;

  cu_bus_xfer #(.NUM_REGS(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_src_i  (cmd_src),
    .cmd_dst_i  (cmd_dst),
    .reg_data_i (reg_data),
    .bus_data_o (bus_data),
    .load_en_o  (load_en),
    .reg_clr_o  (reg_clr),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic obs(input string tag, input logic rdy, input logic [15:0] bus,
                     input logic [7:0] ld, input logic [7:0] clr, input logic dn, input logic er);
    check({tag, ".ready"}, 32'(cmd_ready), 32'(rdy));
    check({tag, ".bus"}, 32'(bus_data), 32'(bus));
    check({tag, ".load_en"}, 32'(load_en), 32'(ld));
    check({tag, ".reg_clr"}, 32'(reg_clr), 32'(clr));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".err"}, 32'(err), 32'(er));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst);
    cmd_op = op;
    cmd_src = src;
    cmd_dst = dst;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_src = 4'd0;
    cmd_dst = 4'd0;
  endtask

  initial begin
    reg_data[0*16 +: 16] = 16'h0BAD;
    reg_data[1*16 +: 16] = 16'hABCD;
    reg_data[2*16 +: 16] = 16'hFFFF;
    reg_data[3*16 +: 16] = 16'h1234;
    #1 rst_n = 1'b0;
    #2 obs("reset", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    obs("idle", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    // MOVE r3 -> r5; src input is zeroed after acceptance, latched index must be used
    issue(2'b00, 4'd3, 4'd5);
    obs("mv.sel", 0, 16'h0, 8'h0, 8'h0, 0, 0);
    tick();
    obs("mv.load", 0, 16'h1234, 8'h20, 8'h0, 0, 0);
    tick();
    obs("mv.done", 0, 16'h1234, 8'h0, 8'h0, 1, 0);
    tick();
    obs("mv.idle", 1, 16'h1234, 8'h0, 8'h0, 0, 0);
    // CLEAR r7
    issue(2'b01, 4'd0, 4'd7);
    obs("clr.sel", 0, 16'h1234, 8'h0, 8'h0, 0, 0);
    tick();
    obs("clr.load", 0, 16'h0, 8'h0, 8'h80, 0, 0);
    tick();
    obs("clr.done", 0, 16'h0, 8'h0, 8'h0, 1, 0);
    tick();
    obs("clr.idle", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    // rejects: src out of range, reserved op, dst out of range
    issue(2'b00, 4'd9, 4'd1);
    obs("rej.src", 1, 16'h0, 8'h0, 8'h0, 0, 1);
    tick();
    obs("rej.src2", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    issue(2'b11, 4'd1, 4'd1);
    obs("rej.op", 1, 16'h0, 8'h0, 8'h0, 0, 1);
    issue(2'b00, 4'd1, 4'd8);
    obs("rej.dst", 1, 16'h0, 8'h0, 8'h0, 0, 1);
    tick();
    obs("rej.end", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    // MOVE r2 -> r2 (src == dst)
    issue(2'b00, 4'd2, 4'd2);
    tick();
    obs("self.load", 0, 16'hFFFF, 8'h04, 8'h0, 0, 0);
    tick();
    obs("self.done", 0, 16'hFFFF, 8'h0, 8'h0, 1, 0);
    tick();
    // INC r2 -> r2 wraps 0xFFFF to 0x0000, or is rejected without the feature
    issue(2'b10, 4'd2, 4'd2);
`ifdef CU_XFER_INC_EN
    obs("inc.sel", 0, 16'hFFFF, 8'h0, 8'h0, 0, 0);
    tick();
    obs("inc.load", 0, 16'h0000, 8'h04, 8'h0, 0, 0);
    tick();
    obs("inc.done", 0, 16'h0000, 8'h0, 8'h0, 1, 0);
    tick();
    obs("inc.idle", 1, 16'h0000, 8'h0, 8'h0, 0, 0);
`else
    obs("inc.rej", 1, 16'hFFFF, 8'h0, 8'h0, 0, 1);
    tick();
    obs("inc.idle", 1, 16'hFFFF, 8'h0, 8'h0, 0, 0);
`endif
    // back-to-back: valid held high, second acceptance four edges after the first
    cmd_op = 2'b00;
    cmd_src = 4'd1;
    cmd_dst = 4'd4;
    cmd_valid = 1'b1;
    tick();
    check("b2b.sel1.ready", 32'(cmd_ready), 32'd0);
    tick();
    check("b2b.load1.ld", 32'(load_en), 32'h10);
    check("b2b.load1.bus", 32'(bus_data), 32'hABCD);
    tick();
    check("b2b.done1", 32'(done), 32'd1);
    check("b2b.done1.ready", 32'(cmd_ready), 32'd0);
    tick();
    check("b2b.idle.ready", 32'(cmd_ready), 32'd1);
    check("b2b.idle.done", 32'(done), 32'd0);
    tick();
    check("b2b.sel2.ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    tick();
    check("b2b.load2.ld", 32'(load_en), 32'h10);
    tick();
    check("b2b.done2", 32'(done), 32'd1);
    tick();
    // reset asserted during LOAD aborts the transfer at once
    issue(2'b00, 4'd3, 4'd6);
    tick();
    obs("abort.load", 0, 16'h1234, 8'h40, 8'h0, 0, 0);
    #1 rst_n = 1'b0;
    #1 obs("abort.now", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    tick();
    obs("abort.hold", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    rst_n = 1'b1;
    tick();
    obs("abort.after1", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    tick();
    obs("abort.after2", 1, 16'h0, 8'h0, 8'h0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
